matrix_scan_capture: RTL
========================

MATRIX_SCAN_CAPTURE -- requirements
Module: matrix_scan_capture

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 4: number of consecutive identical registered input samples required before a row is accepted (range 2..255).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 65536: number of cycles without an accepted row before the link is declared idle.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port matrix_scanout  input  8  row select, one-hot, bit n = row n.
REQ-006 SHALL have port matrix_segout_r  input  8  red column data for the selected row.
REQ-007 SHALL have port matrix_segout_g  input  8  green column data for the selected row.
REQ-008 SHALL have port rd_row  input  3  read address into the published frame.
REQ-009 SHALL have port rd_r / rd_g  output  8 each  red/green data of published row rd_row.
REQ-010 SHALL have port frame_valid  output  1  one-cycle pulse when a new frame is published.
REQ-011 SHALL have port frame_count  output  16  published-frame counter.
REQ-012 SHALL have port err_multi / err_order  output  1 each  one-cycle error pulses.
REQ-013 SHALL have port scan_active  output  1  high while rows arrive within TIMEOUT_CYCLES.

Function
REQ-014 SHALL register {scanout, segout_r, segout_g} every cycle (input stage, 1 cycle).
REQ-015 SHALL count consecutive cycles where the registered 24-bit value equals the previous one; any difference resets the count to 0; the count saturates.
REQ-016 SHALL raise exactly one accept event per stable period, in the cycle the count reaches SETTLE_CYCLES-1; no further accept until the value changes.
REQ-017 Accept with scanout == 0: blanking; SHALL be ignored (no store, no error, no timeout reload).
REQ-018 Accept with more than one scanout bit set: SHALL pulse err_multi next cycle, discard the sample, leave the partial frame intact.
REQ-019 Accept with one-hot row 0: SHALL restart the frame: store row 0 into the shadow buffer, expected row = 1, regardless of prior state.
REQ-020 Accept with one-hot row n (1..7) equal to expected: SHALL store into shadow[n], expected = n+1.
REQ-021 Accept with one-hot row n != expected and n != 0: SHALL pulse err_order next cycle, discard the partial frame, expected = 0 (wait for row 0).
REQ-022 Accepting row 7 in order: SHALL copy shadow rows 0..6 plus the row-7 data into the published frame buffer in the same edge, pulse frame_valid in the following cycle, increment frame_count (wraps 0xFFFF->0), expected = 0.
REQ-023 Published frame buffer SHALL change only per REQ-022; partial frames are never visible.
REQ-024 rd_r/rd_g SHALL be registered, 1-cycle latency from rd_row; a read in the publish cycle returns the old frame.
REQ-025 Every one-hot accept SHALL reload the idle counter to TIMEOUT_CYCLES and set scan_active.
REQ-026 Idle counter reaching 0: SHALL clear scan_active, discard the partial frame, expected = 0; the published frame and frame_count are kept.

Reset
REQ-027 reset high SHALL immediately clear all outputs, both buffers, input registers, stable count, idle counter and expected row to 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; capture resumes at the next row-0 accept after reset deasserts.

Verification
REQ-029 Rows 0..7 each held 16 cycles, row n r=8'h10+n, g=8'hA0+n -> one frame_valid, frame_count=1, rd_row=5 gives r=8'h15 g=8'hA5.
REQ-030 Row 2 held only 3 cycles (SETTLE_CYCLES=4) between rows 1 and 3 -> row 3 triggers err_order, no frame_valid.
REQ-031 scanout=8'b0001_0100 held 16 cycles -> single err_multi pulse, expected row unchanged.
REQ-032 Rows 0..4 then row 0..7 -> exactly one frame, data from the second pass only.
REQ-033 Rows 0..3 then silence TIMEOUT_CYCLES+2 cycles -> scan_active falls, rows 4..7 afterward produce no frame.
REQ-034 reset asserted while row 5 is settling -> all outputs 0 within the same cycle; subsequent full 0..7 pass gives frame_count=1.

Source files
------------

// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture: debounces a scanned LED-matrix bus and assembles accepted rows
// into a shadow frame, publishing complete red/green frames with order, multi-row and idle checks.
module matrix_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  matrix_scanout,
    input  logic [7:0]  matrix_segout_r,
    input  logic [7:0]  matrix_segout_g,
    input  logic [2:0]  rd_row,
    output logic [7:0]  rd_r,
    output logic [7:0]  rd_g,
    output logic        frame_valid,
    output logic [15:0] frame_count,
    output logic        err_multi,
    output logic        err_order,
    output logic        scan_active
);
    localparam int         IW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] ACCEPT_AT = 8'(SETTLE_CYCLES - 1);

    logic [23:0]   in_q, in_d, prev_q, prev_d;
    logic [7:0]    stable_q, stable_d;
    logic [2:0]    expected_q, expected_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          scan_active_q, scan_active_d;
    logic          frame_valid_q, frame_valid_d;
    logic          err_multi_q, err_multi_d;
    logic          err_order_q, err_order_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic [7:0]    rd_r_q, rd_r_d, rd_g_q, rd_g_d;
    logic [7:0]    shadow_r_q [0:6];
    logic [7:0]    shadow_r_d [0:6];
    logic [7:0]    shadow_g_q [0:6];
    logic [7:0]    shadow_g_d [0:6];
    logic [7:0]    pub_r_q [0:7];
    logic [7:0]    pub_r_d [0:7];
    logic [7:0]    pub_g_q [0:7];
    logic [7:0]    pub_g_d [0:7];

    logic       accept, acc_onehot, acc_multi;
    logic [7:0] acc_scan, acc_r, acc_g;
    logic [2:0] acc_row;

    always_comb begin
        in_d          = {matrix_scanout, matrix_segout_r, matrix_segout_g};
        prev_d        = in_q;
        stable_d      = 8'd0;
        expected_d    = expected_q;
        idle_d        = idle_q;
        scan_active_d = scan_active_q;
        frame_valid_d = 1'b0;
        err_multi_d   = 1'b0;
        err_order_d   = 1'b0;
        frame_count_d = frame_count_q;
        shadow_r_d    = shadow_r_q;
        shadow_g_d    = shadow_g_q;
        pub_r_d       = pub_r_q;
        pub_g_d       = pub_g_q;
        rd_r_d        = pub_r_q[rd_row];
        rd_g_d        = pub_g_q[rd_row];

        if (in_q == prev_q) begin
            stable_d = (stable_q == 8'hFF) ? stable_q : stable_q + 8'd1;
        end

        // The settled sample is the older register: it is the last of the identical run.
        accept     = (stable_q == ACCEPT_AT);
        acc_scan   = prev_q[23:16];
        acc_r      = prev_q[15:8];
        acc_g      = prev_q[7:0];
        acc_onehot = $onehot(acc_scan);
        acc_multi  = (acc_scan != 8'd0) && !acc_onehot;
        acc_row    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (acc_scan[i]) acc_row = 3'(i);
        end

        if (accept && acc_multi) begin
            err_multi_d = 1'b1;
        end

        if (accept && acc_onehot) begin
            idle_d        = IW'(TIMEOUT_CYCLES);
            scan_active_d = 1'b1;
            if (acc_row == 3'd0) begin
                shadow_r_d[0] = acc_r;
                shadow_g_d[0] = acc_g;
                expected_d    = 3'd1;
            end else if (acc_row == expected_q) begin
                if (acc_row == 3'd7) begin
                    for (int i = 0; i < 7; i++) begin
                        pub_r_d[i] = shadow_r_q[i];
                        pub_g_d[i] = shadow_g_q[i];
                    end
                    pub_r_d[7]    = acc_r;
                    pub_g_d[7]    = acc_g;
                    frame_valid_d = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    expected_d    = 3'd0;
                end else begin
                    for (int i = 1; i < 7; i++) begin
                        if (acc_row == 3'(i)) begin
                            shadow_r_d[i] = acc_r;
                            shadow_g_d[i] = acc_g;
                        end
                    end
                    expected_d = acc_row + 3'd1;
                end
            end else begin
                err_order_d = 1'b1;
                expected_d  = 3'd0;
            end
        end else if (idle_q != '0) begin
            idle_d = idle_q - IW'(1);
            if (idle_q == IW'(1)) begin
                scan_active_d = 1'b0;
                expected_d    = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q          <= '0;
            prev_q        <= '0;
            stable_q      <= '0;
            expected_q    <= '0;
            idle_q        <= '0;
            scan_active_q <= 1'b0;
            frame_valid_q <= 1'b0;
            err_multi_q   <= 1'b0;
            err_order_q   <= 1'b0;
            frame_count_q <= '0;
            rd_r_q        <= '0;
            rd_g_q        <= '0;
            for (int i = 0; i < 7; i++) begin
                shadow_r_q[i] <= '0;
                shadow_g_q[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                pub_r_q[i] <= '0;
                pub_g_q[i] <= '0;
            end
        end else begin
            in_q          <= in_d;
            prev_q        <= prev_d;
            stable_q      <= stable_d;
            expected_q    <= expected_d;
            idle_q        <= idle_d;
            scan_active_q <= scan_active_d;
            frame_valid_q <= frame_valid_d;
            err_multi_q   <= err_multi_d;
            err_order_q   <= err_order_d;
            frame_count_q <= frame_count_d;
            rd_r_q        <= rd_r_d;
            rd_g_q        <= rd_g_d;
            shadow_r_q    <= shadow_r_d;
            shadow_g_q    <= shadow_g_d;
            pub_r_q       <= pub_r_d;
            pub_g_q       <= pub_g_d;
        end
    end

    assign rd_r        = rd_r_q;
    assign rd_g        = rd_g_q;
    assign frame_valid = frame_valid_q;
    assign frame_count = frame_count_q;
    assign err_multi   = err_multi_q;
    assign err_order   = err_order_q;
    assign scan_active = scan_active_q;
endmodule
